// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one radix-2 step per cycle.
// Magnitude datapath with sign fixup; optional 1-cycle divide special cases.
module muldiv_unit #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, mc, sv;
  logic            is_div, hi_sel, is_rem, neg_q, neg_r, spec;

  logic            a_s, b_s, a_neg, b_neg, dz, ovf, sp;
  logic [XLEN-1:0] a_mag, b_mag, sp_val;

  always_comb begin
    a_s    = op[2] ? !op[0] : (op[1:0] != 2'b11);
    b_s    = op[2] ? !op[0] : !op[1];
    a_neg  = a_s & a[XLEN-1];
    b_neg  = b_s & b[XLEN-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    dz     = (b == '0);
    ovf    = !op[0] && (a == MIN) && (b == '1);
    sp     = op[2] && (dz || ovf);
    // overflow quotient is MIN, which is a itself
    if (op[1]) sp_val = dz ? a : '0;
    else       sp_val = dz ? '1 : a;
  end

  logic [XLEN:0]   sum, sh;
  logic            ge;
  logic [XLEN-1:0] rsub;

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    sh   = {hi, lo[XLEN-1]};
    ge   = (sh >= {1'b0, mc});
    rsub = sh[XLEN-1:0] - mc;
  end

  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0]   q_f, r_f, fin;

  always_comb begin
    prod_f = neg_q ? -{hi, lo} : {hi, lo};
    q_f    = neg_q ? -lo : lo;
    r_f    = neg_r ? -hi : hi;
    if (spec)        fin = sv;
    else if (is_div) fin = is_rem ? r_f : q_f;
    else if (hi_sel) fin = prod_f[2*XLEN-1:XLEN];
    else             fin = prod_f[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      mc     <= '0;
      sv     <= '0;
      is_div <= 1'b0;
      hi_sel <= 1'b0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      spec   <= 1'b0;
      result <= '0;
    end else if (flush && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          is_div <= op[2];
          hi_sel <= (op[1:0] != 2'b00);
          is_rem <= op[1];
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          spec   <= sp;
          sv     <= sp_val;
          hi     <= '0;
          lo     <= op[2] ? a_mag : b_mag;
          mc     <= op[2] ? b_mag : a_mag;
          cnt    <= CW'(XLEN - 1);
          if (FAST_SPECIAL && sp) begin
            state  <= DONE;
            result <= sp_val;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          if (is_div) begin
            hi <= ge ? rsub : sh[XLEN-1:0];
            lo <= {lo[XLEN-2:0], ge};
          end else begin
            hi <= sum[XLEN:1];
            lo <= {sum[0], lo[XLEN-1:1]};
          end
          if (cnt == '0) state <= FIXUP;
          else           cnt   <= cnt - 1'b1;
        end
        FIXUP: begin
          state  <= DONE;
          result <= fin;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: three instances (32/fast,
// 32/slow, 8/fast) checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[3], start[3], flush[3], busy[3], done[3];
  logic [2:0]  opv[3];
  logic [31:0] av[2], bv[2], rv[2];
  logic [7:0]  a8, b8, r8;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .op(opv[0]),
    .a(av[0]), .b(bv[0]), .flush(flush[0]),
    .busy(busy[0]), .done(done[0]), .result(rv[0]));

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b0)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .op(opv[1]),
    .a(av[1]), .b(bv[1]), .flush(flush[1]),
    .busy(busy[1]), .done(done[1]), .result(rv[1]));

  muldiv_unit #(.XLEN(8), .FAST_SPECIAL(1'b1)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .op(opv[2]),
    .a(a8), .b(b8), .flush(flush[2]),
    .busy(busy[2]), .done(done[2]), .result(r8));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  function automatic int width_of(input int u);
    return (u == 2) ? 8 : 32;
  endfunction

  // Reference: plain signed/unsigned arithmetic at width w
  function automatic logic [31:0] model(input int w, input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint mask, ua, ub, sa, sb, p, v;
    logic [63:0] pu, xa, xb;
    mask = (64'sd1 <<< w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = a[w-1] ? ua - (64'sd1 <<< w) : ua;
    sb = b[w-1] ? ub - (64'sd1 <<< w) : ub;
    v = 0;
    case (op)
      3'd0: begin p = sa * sb; v = p; end
      3'd1: begin p = sa * sb; v = p >>> w; end
      3'd2: begin p = sa * ub; v = p >>> w; end
      3'd3: begin
        xa = ua; xb = ub; pu = xa * xb; v = longint'(pu >> w);
      end
      3'd4: begin
        if (ub == 0) v = -1;
        else if (sa == -(64'sd1 <<< (w-1)) && sb == -1) v = sa;
        else v = sa / sb;
      end
      3'd5: v = (ub == 0) ? -1 : ua / ub;
      3'd6: begin
        if (ub == 0) v = sa;
        else if (sa == -(64'sd1 <<< (w-1)) && sb == -1) v = 0;
        else v = sa % sb;
      end
      default: v = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(v & mask);
  endfunction

  function automatic int exp_lat(input int u, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    int w;
    logic [31:0] mask, mn;
    bit sp;
    w = width_of(u);
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    mn = 32'd1 << (w - 1);
    sp = op[2] && (((b & mask) == 0) ||
         (!op[0] && (a & mask) == mn && (b & mask) == mask));
    return (sp && u != 1) ? 1 : w + 2;
  endfunction

  task automatic drive(input int u, input logic s, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y);
    start[u] = s;
    opv[u] = o;
    if (u == 2) begin
      a8 = x[7:0];
      b8 = y[7:0];
    end else begin
      av[u] = x;
      bv[u] = y;
    end
  endtask

  function automatic logic [31:0] res_of(input int u);
    if (u == 2) return {24'd0, r8};
    return rv[u];
  endfunction

  task automatic wait_done(input int u, output logic [31:0] r,
                           output int lat);
    lat = -1;
    r = '0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done[u]) begin
        lat = k;
        r = res_of(u);
        break;
      end
    end
  endtask

  // start at a negedge, accepted at the next posedge (E0), then scramble inputs
  task automatic run_op(input int u, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int lat);
    @(negedge clk);
    drive(u, 1'b1, o, x, y);
    @(posedge clk);
    #1;
    drive(u, 1'b0, 3'($urandom), $urandom, $urandom);
    wait_done(u, r, lat);
  endtask

  task automatic test_reset;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (busy[u] !== 1'b0 || done[u] !== 1'b0 || res_of(u) !== 32'd0) begin
        errors++;
        $display("FAIL reset[%0d]: busy=%b done=%b result=%h, want 0 0 0",
                 u, busy[u], done[u], res_of(u));
      end
    end
  endtask

  task automatic run_table(input int u, input vec_t v[$], input string nm);
    logic [31:0] r;
    int lat;
    foreach (v[i]) begin
      run_op(u, v[i].op, v[i].a, v[i].b, r, lat);
      checks++;
      if (r !== v[i].r || lat !== v[i].lat) begin
        errors++;
        $display("FAIL %s[%0d] op=%0d: result=%h lat=%0d, want %h lat=%0d",
                 nm, i, v[i].op, r, lat, v[i].r, v[i].lat);
      end
    end
  endtask

  task automatic test_directed;
    vec_t v[$];
    v.push_back(vec_t'{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    v.push_back(vec_t'{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    v.push_back(vec_t'{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
    v.push_back(vec_t'{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34});
    v.push_back(vec_t'{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34});
    v.push_back(vec_t'{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34});
    v.push_back(vec_t'{3'd5, 32'd100, 32'd7, 32'd14, 34});
    v.push_back(vec_t'{3'd7, 32'd100, 32'd7, 32'd2, 34});
    v.push_back(vec_t'{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
    v.push_back(vec_t'{3'd7, 32'd5, 32'd0, 32'd5, 1});
    v.push_back(vec_t'{3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1});
    v.push_back(vec_t'{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    v.push_back(vec_t'{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1});
    run_table(0, v, "directed");
  endtask

  task automatic test_slow_special;
    vec_t v[$];
    v.push_back(vec_t'{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 34});
    v.push_back(vec_t'{3'd7, 32'd5, 32'd0, 32'd5, 34});
    v.push_back(vec_t'{3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 34});
    v.push_back(vec_t'{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34});
    v.push_back(vec_t'{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34});
    v.push_back(vec_t'{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
    run_table(1, v, "slow_special");
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random(input int u, input int n);
    logic [31:0] x, y, r, e;
    logic [2:0] o;
    int lat, el;
    for (int i = 0; i < n; i++) begin
      o = 3'($urandom);
      x = pick($urandom_range(0, 7));
      y = pick($urandom_range(0, 7));
      e = model(width_of(u), o, x, y);
      el = exp_lat(u, o, x, y);
      run_op(u, o, x, y, r, lat);
      checks++;
      if (r !== e || lat !== el) begin
        errors++;
        $display("FAIL random[%0d/%0d] op=%0d a=%h b=%h: result=%h lat=%0d, want %h lat=%0d",
                 u, i, o, x, y, r, lat, e, el);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [31:0] x, y, r, e;
    int lat;
    x = $urandom;
    y = $urandom;
    e = model(32, 3'd0, x, y);
    lat = -1;
    r = '0;
    @(negedge clk);
    drive(0, 1'b1, 3'd0, x, y);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 3'd0, x, y);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 5) begin
        checks++;
        if (busy[0] !== 1'b1) begin
          errors++;
          $display("FAIL ignore_busy: busy=%b, want 1", busy[0]);
        end
        drive(0, 1'b1, 3'd4, ~x, y + 32'd3);
      end else if (k == 6) begin
        drive(0, 1'b0, 3'd5, x ^ 32'h55, ~y);
      end
      if (done[0]) begin
        lat = k;
        r = rv[0];
        break;
      end
    end
    checks++;
    if (r !== e || lat !== 34) begin
      errors++;
      $display("FAIL ignore_start: result=%h lat=%0d, want %h lat=34",
               r, lat, e);
    end
  endtask

  task automatic test_flush;
    logic [31:0] r, e;
    int lat, seen;
    e = model(32, 3'd4, 32'hFFFF_FF00, 32'd9);
    run_op(0, 3'd4, 32'hFFFF_FF00, 32'd9, r, lat);
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL flush_prior: result=%h, want %h", r, e);
    end
    @(negedge clk);
    drive(0, 1'b1, 3'd0, 32'd123, 32'd456);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    flush[0] = 1'b1;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: busy=%b, want 0", busy[0]);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[0]) seen++;
    end
    checks++;
    if (seen !== 0 || rv[0] !== e) begin
      errors++;
      $display("FAIL flush_hold: done_pulses=%0d result=%h, want 0 %h",
               seen, rv[0], e);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    drive(0, 1'b1, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (8) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || rv[0] !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h, want 0 0 0",
               busy[0], done[0], rv[0]);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[0]) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_done: pulses=%0d, want 0", seen);
    end
  endtask

  // start held high from the DONE cycle: ignored there, accepted in IDLE
  task automatic test_back_to_back;
    logic [31:0] r, e, x, y;
    logic [2:0] o;
    int lat;
    run_op(0, 3'd3, 32'd40000, 32'd50000, r, lat);
    for (int i = 0; i < 4; i++) begin
      o = 3'($urandom);
      x = $urandom;
      y = pick($urandom_range(3, 7));
      e = model(32, o, x, y);
      drive(0, 1'b1, o, x, y);
      @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle[%0d]: busy=%b done=%b, want 0 0",
                 i, busy[0], done[0]);
      end
      @(posedge clk);
      #1;
      drive(0, 1'b0, 3'($urandom), $urandom, $urandom);
      wait_done(0, r, lat);
      checks++;
      if (r !== e || lat !== exp_lat(0, o, x, y)) begin
        errors++;
        $display("FAIL b2b[%0d] op=%0d: result=%h lat=%0d, want %h lat=%0d",
                 i, o, r, lat, e, exp_lat(0, o, x, y));
      end
    end
  endtask

  task automatic test_xlen8;
    vec_t v[$];
    v.push_back(vec_t'{3'd4, 32'hF9, 32'h02, 32'hFD, 10});
    v.push_back(vec_t'{3'd1, 32'h80, 32'h80, 32'h40, 10});
    v.push_back(vec_t'{3'd4, 32'h80, 32'hFF, 32'h80, 1});
    run_table(2, v, "xlen8");
    test_random(2, 20);
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1;
      flush[u] = 1'b0;
      drive(u, 1'b0, 3'd0, 32'd0, 32'd0);
    end
    repeat (3) @(negedge clk);
    test_reset;
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;
    @(negedge clk);
    test_reset;
    test_directed;
    test_slow_special;
    test_random(0, 30);
    test_random(1, 8);
    test_ignore_start;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    test_xlen8;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
